cpu_bus_if: RTL and testbench



---
 rtl/cpu_bus_if_if.sv | 40 ++++
 rtl/cpu_bus_if.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_bus_if.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_if_if.sv
// Bundles the CPU-side request signals and the bus-side handshake of the load/store bus interface.
// The design uses the master modport; the CPU/bus environment uses the slave modport.
interface cpu_bus_if_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              cpu_req;
   logic              cpu_rw;
   logic [1:0]        cpu_size;
   logic              cpu_signed;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;
   logic              cpu_err;
   logic              bus_valid;
   logic              bus_rw;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [BE_W-1:0]   bus_be;
   logic              bus_ready;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      input  cpu_req, cpu_rw, cpu_size, cpu_signed, cpu_addr, cpu_wdata,
      input  bus_ready, bus_rdata,
      output cpu_stall, cpu_rdata, cpu_done, cpu_err,
      output bus_valid, bus_rw, bus_addr, bus_wdata, bus_be
   );

   modport slave (
      output cpu_req, cpu_rw, cpu_size, cpu_signed, cpu_addr, cpu_wdata,
      output bus_ready, bus_rdata,
      input  cpu_stall, cpu_rdata, cpu_done, cpu_err,
      input  bus_valid, bus_rw, bus_addr, bus_wdata, bus_be
   );
endinterface

// File: rtl/cpu_bus_if.sv
// Handshaked load/store bus interface with sizing, byte enables, load extension, alignment check and timeout.
// Optional macro BUS_STATS_EN adds saturating 16-bit transaction/error counters (stat_txn, stat_err).
module cpu_bus_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15,
   parameter int BE_W    = DATA_W / 8
) (
   input  logic         clk,
   input  logic         rst,
   cpu_bus_if_if.master bif
`ifdef BUS_STATS_EN
   ,
   output logic [15:0]  stat_txn,
   output logic [15:0]  stat_err
`endif
);
   localparam int LANE_W = $clog2(BE_W);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              bus_valid_q, bus_valid_d;
   logic              bus_rw_q, bus_rw_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [BE_W-1:0]   bus_be_q, bus_be_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic              cpu_err_q, cpu_err_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [LANE_W-1:0] lane_q, lane_d;

   logic [3:0]        size_bytes;
   logic              illegal;
   logic              misaligned;
   logic [DATA_W-1:0] rd_shifted;

   function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d, input logic [1:0] sz);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) begin
         case (sz)
            2'b00:   r[i] = d[i % 8];
            2'b01:   r[i] = d[i % 16];
            2'b10:   r[i] = d[i % 32];
            default: r[i] = d[i];
         endcase
      end
      return r;
   endfunction

   function automatic logic [BE_W-1:0] lane_mask(input logic [LANE_W-1:0] lane, input logic [3:0] nb);
      logic [BE_W-1:0] m;
      m = '0;
      for (int i = 0; i < BE_W; i++) begin
         m[i] = (i >= int'(lane)) && (i < int'(lane) + int'(nb));
      end
      return m;
   endfunction

   // raw is already right-justified; bits above the access size become the fill bit
   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw, input logic [1:0] sz,
                                                input logic sgn);
      logic [DATA_W-1:0] r;
      int                nb;
      logic              fill;
      nb = 8 << sz;
      if (nb > DATA_W) nb = DATA_W;
      fill = sgn & raw[nb-1];
      r = '0;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = (i < nb) ? raw[i] : fill;
      end
      return r;
   endfunction

   assign size_bytes = 4'd1 << bif.cpu_size;
   assign illegal    = (32'(size_bytes) > BE_W);
   assign misaligned = (bif.cpu_addr[LANE_W-1:0] & LANE_W'(size_bytes - 4'd1)) != '0;
   assign rd_shifted = bif.bus_rdata >> {lane_q, 3'b000};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_valid_d = bus_valid_q;
      bus_rw_d    = bus_rw_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      cpu_rdata_d = cpu_rdata_q;
      cpu_done_d  = 1'b0;
      cpu_err_d   = 1'b0;
      size_d      = size_q;
      sgn_d       = sgn_q;
      lane_d      = lane_q;
      case (state_q)
         S_IDLE: begin
            if (bif.cpu_req) begin
               if (illegal || misaligned) begin
                  state_d     = S_DONE;
                  cpu_done_d  = 1'b1;
                  cpu_err_d   = 1'b1;
                  cpu_rdata_d = '0;
               end else begin
                  state_d     = S_REQ;
                  cnt_d       = '0;
                  bus_valid_d = 1'b1;
                  bus_rw_d    = bif.cpu_rw;
                  bus_addr_d  = {bif.cpu_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                  bus_be_d    = lane_mask(bif.cpu_addr[LANE_W-1:0], size_bytes);
                  bus_wdata_d = replicate(bif.cpu_wdata, bif.cpu_size);
                  size_d      = bif.cpu_size;
                  sgn_d       = bif.cpu_signed;
                  lane_d      = bif.cpu_addr[LANE_W-1:0];
               end
            end
         end
         S_REQ: begin
            // ready wins over timeout, so a response on the last allowed cycle still succeeds
            if (bif.bus_ready) begin
               state_d     = S_DONE;
               bus_valid_d = 1'b0;
               cpu_done_d  = 1'b1;
               cpu_rdata_d = bus_rw_q ? '0 : extend(rd_shifted, size_q, sgn_q);
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d     = S_DONE;
               bus_valid_d = 1'b0;
               cpu_done_d  = 1'b1;
               cpu_err_d   = 1'b1;
               cpu_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d     = S_IDLE;
            bus_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bus_valid_q <= 1'b0;
         bus_rw_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         cpu_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         size_q      <= '0;
         sgn_q       <= 1'b0;
         lane_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_valid_q <= bus_valid_d;
         bus_rw_q    <= bus_rw_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_done_q  <= cpu_done_d;
         cpu_err_q   <= cpu_err_d;
         size_q      <= size_d;
         sgn_q       <= sgn_d;
         lane_q      <= lane_d;
      end
   end

   assign bif.cpu_stall = ((state_q == S_IDLE) && bif.cpu_req) || (state_q == S_REQ);
   assign bif.cpu_rdata = cpu_rdata_q;
   assign bif.cpu_done  = cpu_done_q;
   assign bif.cpu_err   = cpu_err_q;
   assign bif.bus_valid = bus_valid_q;
   assign bif.bus_rw    = bus_rw_q;
   assign bif.bus_addr  = bus_addr_q;
   assign bif.bus_wdata = bus_wdata_q;
   assign bif.bus_be    = bus_be_q;

`ifdef BUS_STATS_EN
   logic [15:0] stat_txn_q, stat_txn_d;
   logic [15:0] stat_err_q, stat_err_d;

   always_comb begin
      stat_txn_d = stat_txn_q;
      stat_err_d = stat_err_q;
      if (cpu_done_q) begin
         if (stat_txn_q != 16'hFFFF) stat_txn_d = stat_txn_q + 16'd1;
         if (cpu_err_q && (stat_err_q != 16'hFFFF)) stat_err_d = stat_err_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_txn_q <= '0;
         stat_err_q <= '0;
      end else begin
         stat_txn_q <= stat_txn_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_txn = stat_txn_q;
   assign stat_err = stat_err_q;
`endif
endmodule

// File: tb/tb_cpu_bus_if.sv
// Directed bench for cpu_bus_if (DATA_W=32, TIMEOUT=15): sizing, lanes, extension, errors, timeout, reset abort.
module tb_cpu_bus_if;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   nvalid;

   cpu_bus_if_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

`ifdef BUS_STATS_EN
   logic [15:0] stat_txn, stat_err;
   logic [15:0] txn0, err0;
   cpu_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bif(bif), .stat_txn(stat_txn), .stat_err(stat_err));
`else
   cpu_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bif(bif));
`endif

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic req, input logic rw, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
      bif.cpu_req    = req;
      bif.cpu_rw     = rw;
      bif.cpu_size   = sz;
      bif.cpu_signed = sgn;
      bif.cpu_addr   = addr;
      bif.cpu_wdata  = wd;
   endtask

   // legal access with bus_ready in the first REQ cycle
   task automatic run_ok(input string tag, input logic rw, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd);
      drive(1'b1, rw, sz, sgn, addr, wd);
      #1;
      chk({tag, ".stall_c0"}, 64'(bif.cpu_stall), 64'd1);
      tick;
      chk({tag, ".valid_c1"}, 64'(bif.bus_valid), 64'd1);
      chk({tag, ".rw_c1"}, 64'(bif.bus_rw), 64'(rw));
      chk({tag, ".be_c1"}, 64'(bif.bus_be), 64'(exp_be));
      chk({tag, ".addr_c1"}, 64'(bif.bus_addr), 64'(exp_addr));
      chk({tag, ".wdata_c1"}, 64'(bif.bus_wdata), 64'(exp_wd));
      chk({tag, ".stall_c1"}, 64'(bif.cpu_stall), 64'd1);
      chk({tag, ".done_c1"}, 64'(bif.cpu_done), 64'd0);
      bif.cpu_req   = 1'b0;
      bif.bus_ready = 1'b1;
      bif.bus_rdata = rd;
      tick;
      bif.bus_ready = 1'b0;
      chk({tag, ".done_c2"}, 64'(bif.cpu_done), 64'd1);
      chk({tag, ".err_c2"}, 64'(bif.cpu_err), 64'd0);
      chk({tag, ".rdata_c2"}, 64'(bif.cpu_rdata), 64'(exp_rd));
      chk({tag, ".valid_c2"}, 64'(bif.bus_valid), 64'd0);
      chk({tag, ".stall_c2"}, 64'(bif.cpu_stall), 64'd0);
      tick;
      chk({tag, ".done_c3"}, 64'(bif.cpu_done), 64'd0);
   endtask

   // illegal or misaligned access: error completion with no bus cycle
   task automatic run_err(input string tag, input logic [1:0] sz, input logic [31:0] addr);
      drive(1'b1, 1'b0, sz, 1'b0, addr, 32'h0);
      #1;
      chk({tag, ".stall_c0"}, 64'(bif.cpu_stall), 64'd1);
      tick;
      chk({tag, ".done_c1"}, 64'(bif.cpu_done), 64'd1);
      chk({tag, ".err_c1"}, 64'(bif.cpu_err), 64'd1);
      chk({tag, ".rdata_c1"}, 64'(bif.cpu_rdata), 64'd0);
      chk({tag, ".valid_c1"}, 64'(bif.bus_valid), 64'd0);
      chk({tag, ".stall_c1"}, 64'(bif.cpu_stall), 64'd0);
      bif.cpu_req = 1'b0;
      tick;
      chk({tag, ".done_c2"}, 64'(bif.cpu_done), 64'd0);
      chk({tag, ".valid_c2"}, 64'(bif.bus_valid), 64'd0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      bif.bus_ready = 1'b0;
      bif.bus_rdata = 32'h0;
      rst = 1'b1;
      tick;
      tick;
      chk("rst.valid", 64'(bif.bus_valid), 64'd0);
      chk("rst.rw", 64'(bif.bus_rw), 64'd0);
      chk("rst.addr", 64'(bif.bus_addr), 64'd0);
      chk("rst.wdata", 64'(bif.bus_wdata), 64'd0);
      chk("rst.be", 64'(bif.bus_be), 64'd0);
      chk("rst.rdata", 64'(bif.cpu_rdata), 64'd0);
      chk("rst.done", 64'(bif.cpu_done), 64'd0);
      chk("rst.err", 64'(bif.cpu_err), 64'd0);
      chk("rst.stall", 64'(bif.cpu_stall), 64'd0);
`ifdef BUS_STATS_EN
      chk("rst.stat_txn", 64'(stat_txn), 64'd0);
      chk("rst.stat_err", 64'(stat_err), 64'd0);
`endif
      rst = 1'b0;
      tick;

      // bus_ready in IDLE must not produce a completion
      bif.bus_ready = 1'b1;
      bif.bus_rdata = 32'hFFFF_FFFF;
      tick;
      chk("idle_ready.done", 64'(bif.cpu_done), 64'd0);
      chk("idle_ready.valid", 64'(bif.bus_valid), 64'd0);
      bif.bus_ready = 1'b0;
      tick;

      run_ok("ld_w_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
             4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
      run_ok("st_b_103", 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 32'h1234_5678,
             4'b1000, 32'h100, 32'hA5A5_A5A5, 32'h0);
      run_ok("ld_hs_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_1234,
             4'b1100, 32'h100, 32'h0, 32'hFFFF_8001);
      run_ok("ld_hu_102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8001_1234,
             4'b1100, 32'h100, 32'h0, 32'h0000_8001);
      run_ok("ld_bs_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000_8000,
             4'b0010, 32'h100, 32'h0, 32'hFFFF_FF80);
      run_ok("ld_bu_203", 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'hF000_0000,
             4'b1000, 32'h200, 32'h0, 32'h0000_00F0);
      run_ok("st_h_002", 1'b1, 2'b01, 1'b0, 32'h002, 32'h1111_BEEF, 32'h0,
             4'b1100, 32'h000, 32'hBEEF_BEEF, 32'h0);
      run_ok("st_w_004", 1'b1, 2'b10, 1'b0, 32'h004, 32'h1234_5678, 32'h0,
             4'b1111, 32'h004, 32'h1234_5678, 32'h0);

      run_err("mis_w_102", 2'b10, 32'h102);
      run_err("ill_d_100", 2'b11, 32'h100);
      run_err("mis_h_101", 2'b01, 32'h101);

      // timeout: bus_valid must stay up for exactly TIMEOUT cycles
`ifdef BUS_STATS_EN
      txn0 = stat_txn;
      err0 = stat_err;
`endif
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
      tick;
      bif.cpu_req = 1'b0;
      nvalid = 0;
      while (bif.bus_valid === 1'b1 && nvalid < 40) begin
         nvalid++;
         tick;
      end
      chk("tmo.valid_cycles", 64'(nvalid), 64'(TIMEOUT));
      chk("tmo.done", 64'(bif.cpu_done), 64'd1);
      chk("tmo.err", 64'(bif.cpu_err), 64'd1);
      chk("tmo.rdata", 64'(bif.cpu_rdata), 64'd0);
      tick;
      chk("tmo.done_after", 64'(bif.cpu_done), 64'd0);
`ifdef BUS_STATS_EN
      chk("tmo.stat_txn", 64'(stat_txn), 64'(txn0 + 16'd1));
      chk("tmo.stat_err", 64'(stat_err), 64'(err0 + 16'd1));
`endif

      // ready on the last allowed REQ cycle still succeeds
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
      tick;
      bif.cpu_req = 1'b0;
      for (int i = 0; i < TIMEOUT - 1; i++) tick;
      chk("late.valid", 64'(bif.bus_valid), 64'd1);
      chk("late.done_before", 64'(bif.cpu_done), 64'd0);
      bif.bus_ready = 1'b1;
      bif.bus_rdata = 32'hCAFE_F00D;
      tick;
      bif.bus_ready = 1'b0;
      chk("late.done", 64'(bif.cpu_done), 64'd1);
      chk("late.err", 64'(bif.cpu_err), 64'd0);
      chk("late.rdata", 64'(bif.cpu_rdata), 64'hCAFE_F00D);
      tick;

      // reset in the third REQ cycle aborts the transaction
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
      tick;
      bif.cpu_req = 1'b0;
      tick;
      tick;
      chk("abort.valid_c3", 64'(bif.bus_valid), 64'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort.valid", 64'(bif.bus_valid), 64'd0);
      chk("abort.done", 64'(bif.cpu_done), 64'd0);
      chk("abort.stall", 64'(bif.cpu_stall), 64'd0);
      tick;
      chk("abort.done_after", 64'(bif.cpu_done), 64'd0);
      chk("abort.valid_after", 64'(bif.bus_valid), 64'd0);
      run_ok("post_abort", 1'b0, 2'b10, 1'b1, 32'h404, 32'h0, 32'h0BAD_CAFE,
             4'b1111, 32'h404, 32'h0, 32'h0BAD_CAFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
